alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_unit.sv | 79 +++++++
 rtl/alu_multicycle.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and flag index definitions for the multicycle ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_PASSB = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - WIDTH-step shift-add multiplier / restoring divider sharing one datapath
module alu_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_hi_nz
);

    localparam int CW = $clog2(WIDTH) + 1;

    // r_hi: partial-product high half (mul) or remainder (div)
    // r_lo: multiplier being consumed (mul) or dividend turning into quotient (div)
    // r_m : multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic             r_mode;
    logic             r_busy;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;

    // One iteration of either algorithm, computed from the current registers
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_sh   = {r_hi, r_lo[WIDTH-1]};
        w_ge   = (w_sh >= {1'b0, r_m});
        w_diff = w_sh[WIDTH-1:0] - r_m;
        if (r_mode) begin
            w_hi_n = w_ge ? w_diff : w_sh[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[WIDTH:1];
            w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Done is flagged during the last step so the top can capture the final value on that edge
    assign o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_result = w_lo_n;
    assign o_hi_nz  = |w_hi_n;

    // Load operands on start, then step once per cycle for exactly WIDTH cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_m    <= '0;
            r_mode <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_hi   <= '0;
            r_lo   <= i_mode ? i_a : i_b;
            r_m    <= i_mode ? i_b : i_a;
            r_mode <= i_mode;
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_hi   <= w_hi_n;
            r_lo   <= w_lo_n;
            r_cnt  <= o_done ? '0 : r_cnt + 1'b1;
            r_busy <= !o_done;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with single-cycle ops and an iterative mul/div unit
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outAlu,
    output logic [3:0]       flag,
    output logic             err
);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_flag;
    logic             r_err;
    logic             r_is_div;
    logic             r_div0;

    logic             w_accept;
    logic             w_is_iter;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_res;
    logic             w_iter_hi_nz;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_sc_v;
    logic             w_sc_err;
    logic [3:0]       w_sc_flag;
    logic [WIDTH-1:0] w_it_res;
    logic [3:0]       w_it_flag;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_is_iter = (s == OP_MUL) || (s == OP_DIV);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign outAlu    = r_out;
    assign flag      = r_flag;
    assign err       = r_err;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_is_iter),
        .i_mode   (s == OP_DIV),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_iter_done),
        .o_result (w_iter_res),
        .o_hi_nz  (w_iter_hi_nz)
    );

    // Single-cycle result and flags straight from the presented operands
    always_comb begin
        w_add    = {1'b0, a} + {1'b0, b};
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_err = 1'b0;
        case (s)
            OP_ADD: begin
                w_sc_res = w_add[WIDTH-1:0];
                w_sc_c   = w_add[WIDTH];
                w_sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res = a - b;
                w_sc_c   = (a >= b);
                w_sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   w_sc_res = a & b;
            OP_OR:    w_sc_res = a | b;
            OP_SHL:   w_sc_res = a << b[SHW-1:0];
            OP_SHR:   w_sc_res = a >> b[SHW-1:0];
            OP_PASSB: w_sc_res = b;
            OP_MUL, OP_DIV: w_sc_res = '0;
            default:  w_sc_err = 1'b1;
        endcase
        w_sc_flag         = '0;
        w_sc_flag[FLAG_C] = w_sc_c;
        w_sc_flag[FLAG_N] = w_sc_res[WIDTH-1];
        w_sc_flag[FLAG_Z] = (w_sc_res == '0);
        w_sc_flag[FLAG_V] = w_sc_v;
    end

    // Final mul/div result; divide-by-zero overrides whatever the divider produced
    always_comb begin
        w_it_res          = r_div0 ? '1 : w_iter_res;
        w_it_flag         = '0;
        w_it_flag[FLAG_N] = w_it_res[WIDTH-1];
        w_it_flag[FLAG_Z] = (w_it_res == '0);
        w_it_flag[FLAG_V] = !r_is_div && w_iter_hi_nz;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: single-cycle ops skip BUSY
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next = w_is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_iter_done) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Result registers: written at accept (single-cycle) or on the last iteration, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_flag   <= '0;
            r_err    <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= (s == OP_DIV);
            r_div0   <= (s == OP_DIV) && (b == '0);
            if (!w_is_iter) begin
                r_out  <= w_sc_res;
                r_flag <= w_sc_flag;
                r_err  <= w_sc_err;
            end
        end else if ((r_state == ST_BUSY) && w_iter_done) begin
            r_out  <= w_it_res;
            r_flag <= w_it_flag;
            r_err  <= r_div0;
        end
    end

endmodule
